cdc_handshake_sender: RTL and testbench
=======================================

Name: cdc_handshake_sender

Overview:
- Source-domain launcher for multi-bit clock-domain crossings. It is the transmitting end that feeds a destination-side two-flop synchronizer.
- Captures a word through a valid/ready interface and holds it stable on data_out. It announces the word by toggling req_out, then waits for the receiver's toggled ack_in, which it synchronizes internally.
- Guarantees data_out never changes while a crossing is in flight. This makes the bus safe to sample in the destination domain once the synchronized req edge is seen there.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out
SYNC_STAGES, 2, flops in the ack_in synchronizer chain (legal 2..4)
TIMEOUT_CYCLES, 1024, wait cycles before timeout asserts (only with CDC_TX_TIMEOUT_EN)

Ports:
clk_in  input  1  source-domain clock, all logic on posedge
reset_n  input  1  asynchronous, active-low reset
data_in  input  DATA_WIDTH  word to send
valid_in  input  1  data_in valid
ready_out  output  1  block can accept a word
data_out  output  DATA_WIDTH  held word to destination domain
req_out  output  1  request toggle to destination domain (registered)
ack_in  input  1  acknowledge toggle from destination domain (asynchronous to clk_in)
busy  output  1  crossing in flight
protocol_err  output  1  sticky: ack toggled with no request outstanding
timeout  output  1  wait exceeded TIMEOUT_CYCLES (feature only; tied 0 otherwise)

Behaviour:
- Clocking and reset:
  - One clock (clk_in); reset is asynchronous and active-low (reset_n).
  - Reset values: data_out=0, req_out=0, all ack sync stages=0, state=IDLE, protocol_err=0, timeout=0, wait counter=0.
  - Therefore ready_out=1 and busy=0 immediately after reset.
- Ack synchronizer: SYNC_STAGES-deep flop chain on ack_in. ack_s denotes the last stage. No other logic samples ack_in directly.
- States: IDLE, WAIT_ACK. ready_out = (state==IDLE); busy = (state==WAIT_ACK). Both are decoded from registered state, with no combinational path from valid_in.
- IDLE:
  - On an edge with valid_in & ready_out: data_out <= data_in, req_out <= ~req_out, state <= WAIT_ACK.
  - Otherwise hold all registers.
- WAIT_ACK:
  - valid_in is ignored; data_out and req_out must hold.
  - On an edge where ack_s == req_out: state <= IDLE.
- Latency: if ack_in toggles before edge k, ack_s updates at edge k+SYNC_STAGES-1, and state returns to IDLE at edge k+SYNC_STAGES. ready_out is high in the following cycle.
- Throughput:
  - The minimum spacing between accepts is 1 + the receiver's round trip + SYNC_STAGES cycles.
  - A new word may be accepted in the very first cycle ready_out is high.
- Protocol violation: in IDLE, if ack_s != req_out, set protocol_err=1 (sticky, cleared only by reset). The state machine is unaffected.
- Reset mid-WAIT_ACK:
  - Everything returns to reset values asynchronously; req_out drops to 0.
  - The destination side must be reset in the same reset event.
  - Nothing is replayed.
- Width rules: data_out is exactly DATA_WIDTH bits with no padding. The toggle protocol has no sequence numbers, so correctness relies on one outstanding word at a time.

Optional Feature:
Macro CDC_TX_TIMEOUT_EN.
- Defined:
  - A wait counter of width clog2(TIMEOUT_CYCLES)+1 clears on each accept and increments each WAIT_ACK cycle, saturating.
  - timeout goes high when the counter reaches TIMEOUT_CYCLES and stays high until the state returns to IDLE. It then clears on the same edge as the IDLE transition.
  - The handshake is not aborted; data_out and req_out keep holding.
- Not defined: no counter logic exists, and timeout is tied to 0.

Test Plan:
- Reset: assert reset_n=0 mid-cycle with no clock -> data_out=0, req_out=0, ready_out=1, busy=0, protocol_err=0 immediately.
- Single transfer (SYNC_STAGES=2): valid_in=1, data_in=0xA5 at edge 0. Bench toggles ack_in 5 cycles later, before edge 5.
  - Required at edge 0: data_out=0xA5, req_out=1, busy=1.
  - Required: state returns to IDLE at edge 7 and ready_out=1 after edge 7.
- Hold while busy: during WAIT_ACK, drive valid_in=1 with data_in=0x3C every cycle -> data_out stays 0xA5 and req_out stays 1 until the ack completes. 0x3C is then accepted on the first ready cycle and req_out toggles to 0.
- Back-to-back: send 0x01, 0x02, 0x03 with the bench echoing req_out to ack_in after 2 cycles -> req_out toggles 1,0,1. The destination sees each value exactly once, with no accept while busy=1.
- Reset mid-flight: assert reset_n=0 two cycles into WAIT_ACK -> req_out=0, data_out=0, ready_out=1. The next transfer starts with req_out rising 0->1.
- Fault cases:
  - Spurious ack: toggle ack_in while IDLE -> protocol_err=1 SYNC_STAGES+1 edges later, and it stays 1.
  - With CDC_TX_TIMEOUT_EN, TIMEOUT_CYCLES=16 and no ack -> timeout=1 at wait cycle 16. A later ack clears it as the state returns to IDLE.

Source files
------------

// File: rtl/cdc_handshake_sender_if.sv
// Purpose     : bundles the word, valid/ready, req/ack toggle and status lines of cdc_handshake_sender.
// Latency     : none, wiring only.
// Backpressure: ready_out is driven by the sender; the master modport is the sender's view.
// Signals: data_in/valid_in/ready_out (source side), data_out/req_out/ack_in (crossing),
//          busy/protocol_err/timeout (status).
interface cdc_handshake_sender_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  valid_in;
    logic                  ready_out;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  req_out;
    logic                  ack_in;
    logic                  busy;
    logic                  protocol_err;
    logic                  timeout;

    // Sender side.
    modport master (
        input  data_in, valid_in, ack_in,
        output ready_out, data_out, req_out, busy, protocol_err, timeout
    );

    // Source producer and destination receiver side.
    modport slave (
        output data_in, valid_in, ack_in,
        input  ready_out, data_out, req_out, busy, protocol_err, timeout
    );
endinterface

// File: rtl/cdc_handshake_sender.sv
// Purpose     : source-domain launcher of a toggle req/ack multi-bit CDC; holds data_out while in flight.
// Latency     : word on data_out/req_out one edge after accept; IDLE SYNC_STAGES edges after ack_in toggles.
// Backpressure: ready_out=0 for the whole crossing; valid_in is ignored until the ack returns.
// Ports: clk_in, reset_n (async active-low), bus (cdc_handshake_sender_if.master).
// Optional: define CDC_TX_TIMEOUT_EN to build the wait counter and timeout flag; otherwise timeout=0.
module cdc_handshake_sender #(
    parameter int DATA_WIDTH     = 8,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk_in,
    input  logic                    reset_n,
    cdc_handshake_sender_if.master  bus
);

    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("cdc_handshake_sender: SYNC_STAGES must be 2..4 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    req_q, req_d;
    logic                    err_q, err_d;
    logic [SYNC_STAGES-1:0]  ack_sync_q;
    logic                    ack_s;

    // Only the first synchronizer flop ever sees the asynchronous ack_in.
    assign ack_s = ack_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            data_q     <= '0;
            req_q      <= 1'b0;
            err_q      <= 1'b0;
            ack_sync_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            req_q      <= req_d;
            err_q      <= err_d;
            ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.ack_in};
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        req_d   = req_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (bus.valid_in) begin
                    data_d  = bus.data_in;
                    req_d   = ~req_q;
                    state_d = WAIT_ACK;
                end
                // With nothing outstanding the synchronized ack must match req;
                // a mismatch means the receiver toggled on its own.
                if (ack_s != req_q) begin
                    err_d = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (ack_s == req_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Status decodes come from registered state only, never from valid_in.
    assign bus.ready_out    = (state_q == IDLE);
    assign bus.busy         = (state_q == WAIT_ACK);
    assign bus.data_out     = data_q;
    assign bus.req_out      = req_q;
    assign bus.protocol_err = err_q;

`ifdef CDC_TX_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Counter saturates at TIMEOUT_CYCLES so the flag stays up for the rest of
    // the wait; leaving WAIT_ACK drops the flag on the same edge.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        timeout_d  = 1'b0;
        if (state_q == IDLE) begin
            if (bus.valid_in) begin
                wait_cnt_d = '0;
            end
        end else begin
            if (wait_cnt_q != TO_VAL) begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
            if (state_d == WAIT_ACK) begin
                timeout_d = (wait_cnt_d == TO_VAL);
            end
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_sender.sv
// Purpose     : directed bench for cdc_handshake_sender with a req-toggle scoreboard.
// Latency     : checks accept-to-req one edge and ack-to-IDLE SYNC_STAGES edges.
// Backpressure: valid_in is held during WAIT_ACK to show it is ignored.
module tb_cdc_handshake_sender;

`ifdef CDC_TX_TIMEOUT_EN
    localparam int TO_CYC = 16;
`else
    localparam int TO_CYC = 1024;
`endif

    logic clk_in;
    logic reset_n;

    cdc_handshake_sender_if #(.DATA_WIDTH(8)) bus ();

    cdc_handshake_sender #(
        .DATA_WIDTH    (8),
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .clk_in (clk_in),
        .reset_n(reset_n),
        .bus    (bus)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    int tests = 0;
    int fails = 0;
    int sent  = 0;
    int seen  = 0;
    logic [8:0] exp_q[$];   // {req_out, data_out} expected at each req toggle
    logic       exp_req;
    logic       prev_req;
    logic       prev_busy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (bus.ready_out !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (bus.ready_out !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL wait_ready: ready_out stuck at %b, required 1 within 50 cycles", bus.ready_out);
        end
    endtask

    task automatic send(input logic [7:0] d);
        wait_ready();
        bus.valid_in = 1'b1;
        bus.data_in  = d;
        exp_req      = ~exp_req;
        exp_q.push_back({exp_req, d});
        sent++;
        tick();
        bus.valid_in = 1'b0;
    endtask

    // Receiver model: returns the request toggle after n cycles.
    task automatic echo(input int n);
        repeat (n) tick();
        bus.ack_in = bus.req_out;
    endtask

    // Monitor: every req_out toggle is a word presented to the destination.
    always @(negedge clk_in) begin
        if (!reset_n) begin
            prev_req  = bus.req_out;
            prev_busy = bus.busy;
        end else begin
            if (bus.req_out !== prev_req) begin
                seen++;
                chk("accept_while_busy", {31'd0, prev_busy}, 32'd0);
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_word", {23'd0, bus.req_out, bus.data_out}, 32'h1ff);
                end else begin
                    chk("sb_word", {23'd0, bus.req_out, bus.data_out}, {23'd0, exp_q.pop_front()});
                end
            end
            prev_req  = bus.req_out;
            prev_busy = bus.busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b1;
        bus.valid_in = 1'b0;
        bus.data_in  = 8'h00;
        bus.ack_in   = 1'b0;
        exp_req      = 1'b0;
        prev_req     = 1'b0;
        prev_busy    = 1'b0;

        // Asynchronous reset before any clock edge.
        #2 reset_n = 1'b0;
        #1;
        chk("rst_data_out", {24'd0, bus.data_out}, 32'h00);
        chk("rst_req_out",  {31'd0, bus.req_out}, 32'd0);
        chk("rst_ready",    {31'd0, bus.ready_out}, 32'd1);
        chk("rst_busy",     {31'd0, bus.busy}, 32'd0);
        chk("rst_perr",     {31'd0, bus.protocol_err}, 32'd0);
        chk("rst_timeout",  {31'd0, bus.timeout}, 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // Single transfer 0xA5, with 0x3C held on the input while busy.
        bus.valid_in = 1'b1;
        bus.data_in  = 8'hA5;
        exp_req      = ~exp_req;
        exp_q.push_back({exp_req, 8'hA5});
        sent++;
        tick();                              // edge 0
        chk("e0_data_out", {24'd0, bus.data_out}, 32'hA5);
        chk("e0_req_out",  {31'd0, bus.req_out}, 32'd1);
        chk("e0_busy",     {31'd0, bus.busy}, 32'd1);
        bus.data_in = 8'h3C;                 // valid_in stays 1
        exp_req     = ~exp_req;
        exp_q.push_back({exp_req, 8'h3C});
        sent++;
        repeat (4) tick();                   // edge 4
        bus.ack_in = 1'b1;                   // toggles before edge 5
        tick();
        tick();                              // edge 6
        chk("e6_busy",     {31'd0, bus.busy}, 32'd1);
        chk("e6_ready",    {31'd0, bus.ready_out}, 32'd0);
        chk("e6_hold_data",{24'd0, bus.data_out}, 32'hA5);
        chk("e6_hold_req", {31'd0, bus.req_out}, 32'd1);
        chk("e6_timeout",  {31'd0, bus.timeout}, 32'd0);
        tick();                              // edge 7: back to IDLE
        chk("e7_ready",    {31'd0, bus.ready_out}, 32'd1);
        chk("e7_busy",     {31'd0, bus.busy}, 32'd0);
        chk("e7_hold_data",{24'd0, bus.data_out}, 32'hA5);
        tick();                              // edge 8: 0x3C accepted at once
        bus.valid_in = 1'b0;
        chk("e8_data_out", {24'd0, bus.data_out}, 32'h3C);
        chk("e8_req_out",  {31'd0, bus.req_out}, 32'd0);
        chk("e8_busy",     {31'd0, bus.busy}, 32'd1);
        echo(2);
        wait_ready();

        // Back-to-back words, req expected 1,0,1.
        send(8'h01); echo(2);
        send(8'h02); echo(2);
        send(8'h03); echo(2);
        wait_ready();
        chk("b2b_last_req", {31'd0, bus.req_out}, 32'd1);

        // Reset two cycles into WAIT_ACK of a req=1 word.
        send(8'h55); echo(2);
        send(8'h66);
        tick();
        tick();
        #2 reset_n = 1'b0;
        bus.ack_in = 1'b0;                   // destination reset in the same event
        exp_req    = 1'b0;
        #1;
        chk("mid_rst_req",   {31'd0, bus.req_out}, 32'd0);
        chk("mid_rst_data",  {24'd0, bus.data_out}, 32'h00);
        chk("mid_rst_ready", {31'd0, bus.ready_out}, 32'd1);
        tick();
        reset_n = 1'b1;
        tick();
        send(8'h77);
        chk("post_rst_req",  {31'd0, bus.req_out}, 32'd1);
        chk("post_rst_data", {24'd0, bus.data_out}, 32'h77);
        echo(3);
        wait_ready();

`ifdef CDC_TX_TIMEOUT_EN
        // No ack for TIMEOUT_CYCLES wait cycles.
        send(8'h88);                         // now just after accept edge
        repeat (15) tick();
        chk("to_before", {31'd0, bus.timeout}, 32'd0);
        tick();                              // wait cycle 16
        chk("to_set",    {31'd0, bus.timeout}, 32'd1);
        chk("to_hold_data", {24'd0, bus.data_out}, 32'h88);
        bus.ack_in = bus.req_out;
        tick();
        tick();
        chk("to_still",  {31'd0, bus.timeout}, 32'd1);
        tick();                              // IDLE edge
        chk("to_clear",  {31'd0, bus.timeout}, 32'd0);
        chk("to_ready",  {31'd0, bus.ready_out}, 32'd1);
`endif

        // Spurious ack while IDLE.
        chk("perr_clean", {31'd0, bus.protocol_err}, 32'd0);
        bus.ack_in = ~bus.ack_in;            // before edge k
        tick();                              // k
        tick();                              // k+1
        chk("perr_early", {31'd0, bus.protocol_err}, 32'd0);
        tick();                              // k+2
        chk("perr_set",   {31'd0, bus.protocol_err}, 32'd1);
        chk("perr_ready", {31'd0, bus.ready_out}, 32'd1);
        repeat (5) tick();
        chk("perr_sticky", {31'd0, bus.protocol_err}, 32'd1);

        chk("sb_all_seen", seen, sent);
        chk("sb_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
